// File: rtl/ring_counter.sv
// Loadable WIDTH-bit ring counter: parallel load of a seed, then rotate right one place per clock.
// Optional build macro RING_COUNTER_SELFCORRECT_EN reseeds an all-zero ring with RESET_VALUE in rotate mode.
module ring_counter #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {1'b1, {(WIDTH-1){1'b0}}}
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             mode,
    input  logic [WIDTH-1:0] init,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    function automatic logic [WIDTH-1:0] rotate_right(input logic [WIDTH-1:0] value);
        return {value[0], value[WIDTH-1:1]};
    endfunction

    function automatic logic is_zero(input logic [WIDTH-1:0] value);
        return (value == {WIDTH{1'b0}});
    endfunction

    // Next-state selection: load the seed, or rotate the current pattern.
    always_comb begin
        count_d = count_q;
        case (mode)
            1'b1: begin
                count_d = init;
            end
            1'b0: begin
`ifdef RING_COUNTER_SELFCORRECT_EN
                // A lost token is recovered by reseeding rather than rotating zeros.
                if (is_zero(count_q)) begin
                    count_d = RESET_VALUE;
                end else begin
                    count_d = rotate_right(count_q);
                end
`else
                if (is_zero(count_q)) begin
                    count_d = {WIDTH{1'b0}};
                end else begin
                    count_d = rotate_right(count_q);
                end
`endif
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // State register; clr clears it asynchronously and overrides load and rotate.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_q <= RESET_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_ring_counter.sv
// Self-checking bench for ring_counter: table-driven vectors plus hand-written async-clear and zero-seed sequences.
module tb_ring_counter;

    logic       clk;
    logic       clr;
    logic       mode;
    logic [3:0] init;
    logic [3:0] count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       clr;
        logic       mode;
        logic [3:0] init;
        logic [3:0] exp;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    ring_counter #(.WIDTH(4), .RESET_VALUE(4'b1000)) dut (
        .clk   (clk),
        .clr   (clr),
        .mode  (mode),
        .init  (init),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] exp);
        checks = checks + 1;
        if (count !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: count=%b expected=%b", name, count, exp);
        end
    endtask

    task automatic apply_edge(input logic c, input logic m, input logic [3:0] i);
        @(negedge clk);
        clr  = c;
        mode = m;
        init = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0100};
        vecs[1]  = '{1'b1, 1'b0, 4'b0000, 4'b0010};
        vecs[2]  = '{1'b1, 1'b0, 4'b0000, 4'b0001};
        vecs[3]  = '{1'b1, 1'b0, 4'b0000, 4'b1000};
        vecs[4]  = '{1'b1, 1'b1, 4'b1010, 4'b1010};
        vecs[5]  = '{1'b1, 1'b0, 4'b1111, 4'b0101};
        vecs[6]  = '{1'b1, 1'b0, 4'b0110, 4'b1010};
        vecs[7]  = '{1'b1, 1'b0, 4'b0000, 4'b0101};
        vecs[8]  = '{1'b1, 1'b1, 4'b0011, 4'b0011};
        vecs[9]  = '{1'b1, 1'b1, 4'b1100, 4'b1100};
        vecs[10] = '{1'b0, 1'b1, 4'b0110, 4'b1000};
        vecs[11] = '{1'b1, 1'b0, 4'b0000, 4'b0100};
        vecs[12] = '{1'b1, 1'b0, 4'b0000, 4'b0010};

        clr  = 1'b1;
        mode = 1'b0;
        init = 4'b0000;

        // Async clear between edges, no clock edge needed.
        #2;
        clr = 1'b0;
        #1;
        check("async_clear", 4'b1000);

        // Clear holds and beats a pending load across edges.
        mode = 1'b1;
        init = 4'b0110;
        @(posedge clk);
        #1;
        check("clear_hold_1", 4'b1000);
        @(posedge clk);
        #1;
        check("clear_hold_2", 4'b1000);

        for (int k = 0; k < NVEC; k++) begin
            apply_edge(vecs[k].clr, vecs[k].mode, vecs[k].init);
            check($sformatf("vec%0d", k), vecs[k].exp);
        end

        // Mid-run clear while count=0010 takes effect before the next edge.
        @(negedge clk);
        #2;
        clr = 1'b0;
        #1;
        check("midrun_clear_async", 4'b1000);
        @(posedge clk);
        #1;
        check("midrun_clear_hold", 4'b1000);
        apply_edge(1'b1, 1'b0, 4'b0000);
        check("resume_after_clear", 4'b0100);

        // Zero seed: load honoured, then sticky or reseeded depending on build.
        apply_edge(1'b1, 1'b1, 4'b0000);
        check("zero_load", 4'b0000);
        apply_edge(1'b1, 1'b0, 4'b0000);
`ifdef RING_COUNTER_SELFCORRECT_EN
        check("zero_rotate_1", 4'b1000);
`else
        check("zero_rotate_1", 4'b0000);
`endif
        apply_edge(1'b1, 1'b0, 4'b1111);
`ifdef RING_COUNTER_SELFCORRECT_EN
        check("zero_rotate_2", 4'b0100);
`else
        check("zero_rotate_2", 4'b0000);
`endif

        // Non-one-hot full rotation period.
        apply_edge(1'b1, 1'b1, 4'b0110);
        check("load_0110", 4'b0110);
        apply_edge(1'b1, 1'b0, 4'b0000);
        check("rot_0011", 4'b0011);
        apply_edge(1'b1, 1'b0, 4'b0000);
        check("rot_1001", 4'b1001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
